// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// MEM-stage sequencer for the five-stage MIPS pipeline. It turns the
// EX/MEM memRead/memWrite controls into a req/ack transaction with a
// variable-latency data memory. While the access is outstanding it holds
// the rest of the pipeline in a stall.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   memRead, memWrite   load/store in MEM (store wins if both are set)
//   address, data       EX/MEM byte address and store data
//   memAck, memRData    memory completion strobe and read data (same cycle)
//   memReq, memWe       registered request and direction (1 = write)
//   memAddr, memWData   latched address and store data, stable during REQ
//   readData            last completed load data, held
//   stall               freeze PC..EX/MEM, bubble into MEM/WB
//   memErr              one-cycle timeout pulse (watchdog build only)
//
// Build option: define MEM_STAGE_TIMEOUT_EN to enable the request
// watchdog. TIMEOUT (1..2^CNT_W-1) is the REQ-cycle limit and CNT_W is the
// counter width. Both parameters are unused otherwise.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] address,
    input  logic [31:0] data,
    input  logic        memAck,
    input  logic [31:0] memRData,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        memErr
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      r_state;
    logic        r_memReq;
    logic        r_memWe;
    logic [31:0] r_memAddr;
    logic [31:0] r_memWData;
    logic [31:0] r_readData;
    logic        w_op;

    assign w_op = memRead | memWrite;

    // In IDLE the stall must appear in the cycle the op is first seen. It
    // therefore comes straight from the inputs. In REQ it is held until
    // completion.
    always_comb begin
        stall = 1'b0;
        case (r_state)
            IDLE:    stall = w_op;
            REQ:     stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_memErr;
    logic             w_limit;

    // The limit is hit when the TIMEOUT-th REQ cycle passes without memAck.
    assign w_limit = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign memErr  = r_memErr;
`else
    logic [CNT_W-1:0] w_unused_cfg;

    assign w_unused_cfg = CNT_W'(TIMEOUT);
    assign memErr       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWData <= '0;
            r_readData <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
            r_cnt      <= '0;
            r_memErr   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_op) begin
                        r_state    <= REQ;
                        r_memReq   <= 1'b1;
                        r_memWe    <= memWrite;
                        r_memAddr  <= address;
                        r_memWData <= data;
`ifdef MEM_STAGE_TIMEOUT_EN
                        r_cnt      <= '0;
`endif
                    end
                end
                REQ: begin
                    if (memAck) begin
                        // An ack in the same cycle as the limit completes the access normally.
                        r_state  <= DONE;
                        r_memReq <= 1'b0;
                        if (!r_memWe)
                            r_readData <= memRData;
                    end
`ifdef MEM_STAGE_TIMEOUT_EN
                    else if (w_limit) begin
                        r_state  <= DONE;
                        r_memReq <= 1'b0;
                        r_memErr <= 1'b1;
                        if (!r_memWe)
                            r_readData <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    r_state <= IDLE;
`ifdef MEM_STAGE_TIMEOUT_EN
                    r_memErr <= 1'b0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign memReq   = r_memReq;
    assign memWe    = r_memWe;
    assign memAddr  = r_memAddr;
    assign memWData = r_memWData;
    assign readData = r_readData;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    localparam int unsigned TO = 3;
`ifdef MEM_STAGE_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite, memAck;
    logic [31:0] address, data, memRData;
    logic        memReq, memWe, stall, memErr;
    logic [31:0] memAddr, memWData, readData;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] exp_rd   = '0;

    mem_stage_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
        .address(address), .data(data), .memAck(memAck), .memRData(memRData),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .readData(readData), .stall(stall), .memErr(memErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One instruction through MEM. Expected behaviour is derived at the transaction level.
    // A memory op stalls in its first cycle and then requests for the ack latency
    // (capped by the watchdog). One unstalled DONE cycle follows, carrying the result.
    task automatic op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input int unsigned dly, input logic [31:0] rdat);
        bit          is_mem = rd | wr;
        bit          aborted = WD && (dly > TO);
        int unsigned eff = aborted ? TO : dly;
        @(posedge clk); #1;
        memRead = rd; memWrite = wr; address = a; data = d;
        memAck = 1'($urandom_range(0, 1)); memRData = $urandom;
        @(negedge clk);
        chk("idle_stall", stall, is_mem);
        chk("idle_req", memReq, 0);
        chk("idle_rdata", readData, exp_rd);
        if (!is_mem) return;
        for (int unsigned c = 1; c <= eff; c++) begin
            @(posedge clk); #1;
            memAck   = (c == dly);
            memRData = (c == dly) ? rdat : $urandom;
            address  = $urandom;
            data     = $urandom;
            @(negedge clk);
            chk("req_req", memReq, 1);
            chk("req_stall", stall, 1);
            chk("req_we", memWe, wr);
            chk("req_addr", memAddr, a);
            chk("req_wdata", memWData, d);
            chk("req_rdata", readData, exp_rd);
            chk("req_err", memErr, 0);
        end
        if (rd && !wr) exp_rd = aborted ? 32'h0 : rdat;
        @(posedge clk); #1;
        memAck = 1'($urandom_range(0, 1)); memRData = $urandom;
        @(negedge clk);
        chk("done_req", memReq, 0);
        chk("done_stall", stall, 0);
        chk("done_rdata", readData, exp_rd);
        chk("done_err", memErr, aborted);
    endtask

    initial begin
        rst = 1'b1; memRead = 0; memWrite = 0; memAck = 0;
        address = '0; data = '0; memRData = '0;
        @(negedge clk);
        chk("rst_req", memReq, 0);
        chk("rst_we", memWe, 0);
        chk("rst_addr", memAddr, 0);
        chk("rst_wdata", memWData, 0);
        chk("rst_rdata", readData, 0);
        chk("rst_err", memErr, 0);
        chk("rst_stall0", stall, 0);
        memRead = 1; #1;
        chk("rst_stall1", stall, 1);
        memRead = 0;
        @(negedge clk); rst = 1'b0;

        // Directed cases
        op(1, 0, 32'h40, 32'h0, 1, 32'h1234_5678);
        op(1, 1, 32'h80, 32'hCAFE_F00D, 4, 32'hDEAD_BEEF);
        op(1, 0, 32'h100, 32'h0, 1, 32'h1111_1111);
        op(1, 0, 32'h104, 32'h0, 1, 32'h2222_2222);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            memRead = 0; memWrite = 0; memAck = 1; address = $urandom;
            @(negedge clk);
            chk("nomem_stall", stall, 0);
            chk("nomem_req", memReq, 0);
            chk("nomem_rdata", readData, exp_rd);
        end

        // Asynchronous reset in the middle of REQ
        @(posedge clk); #1;
        memRead = 1; memWrite = 0; memAck = 0; address = 32'h1234;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1; #1;
        exp_rd = '0;
        chk("arst_req", memReq, 0);
        chk("arst_we", memWe, 0);
        chk("arst_addr", memAddr, 0);
        chk("arst_rdata", readData, 0);
        chk("arst_stall", stall, 1);
        memRead = 0; #1;
        chk("arst_stall0", stall, 0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            memAck = 1; memRData = $urandom;
            @(negedge clk);
            chk("arst_ack_req", memReq, 0);
            chk("arst_ack_rdata", readData, 0);
        end

`ifdef MEM_STAGE_TIMEOUT_EN
        op(1, 0, 32'h200, 32'h0, 1, 32'h5A5A_5A5A);
        op(1, 0, 32'h204, 32'h0, 9, 32'h0BAD_0BAD);
        op(1, 0, 32'h208, 32'h0, TO, 32'h0000_BEEF);
        op(0, 1, 32'h20C, 32'h7777_7777, 9, 32'h0);
`endif

        // Randomized op stream
        for (int i = 0; i < 40; i++) begin
            int unsigned k = $urandom_range(0, 3);
            op(k[0], k[1], $urandom, $urandom, $urandom_range(1, 5), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencer for the MEM stage of the five-stage MIPS pipeline. It sits between the EX/MEM pipeline register and a variable-latency data memory. It converts the registered memRead/memWrite controls into a request/acknowledge transaction and raises a pipeline-wide stall until the transaction completes. Load data is held stable for the MEM/WB register.

## Interface
- TIMEOUT, 255: max cycles a request waits for memAck (watchdog build only); legal 1..2^CNT_W-1
- CNT_W, 8: width of the watchdog counter

- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- memRead  in  1  load in MEM stage (from EX/MEM register)
- memWrite  in  1  store in MEM stage (from EX/MEM register)
- address  in  32  byte address (EX/MEM ALU result)
- data  in  32  store data (EX/MEM)
- memAck  in  1  memory completion strobe; memRData valid in the same cycle
- memRData  in  32  memory read data
- memReq  out  1  request to memory, registered
- memWe  out  1  1 = write, 0 = read; valid while memReq
- memAddr  out  32  latched address; valid while memReq
- memWData  out  32  latched store data; valid while memReq
- readData  out  32  last completed load data, held
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB
- memErr  out  1  one-cycle timeout pulse (watchdog build only)

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - stall = memRead|memWrite, combinational.
  - If memRead|memWrite: latch address, data and memWe=memWrite, then go to REQ.
  - memWrite has priority when both are set (treated as a store).
- REQ:
  - memReq=1 and stall=1.
  - memAck is sampled here only. On memAck:
    - A read captures memRData into readData.
    - Go to DONE.
  - memAddr, memWData and memWe stay constant for the whole of REQ.
- DONE:
  - memReq=0 and stall=0, so the pipeline advances at the end of this cycle.
  - Unconditionally return to IDLE. The op seen in the following IDLE is therefore always the next instruction, never a re-issue.
- memAck outside REQ is ignored.
- readData changes only on a read completion or a watchdog abort. Stores leave it untouched.
- Reset values:
  - state=IDLE; memReq=0, memWe=0, memAddr=0, memWData=0, readData=0, memErr=0.
  - stall follows its combinational definition (stall=memRead|memWrite, since state=IDLE).
- Reset mid-transaction: memReq drops immediately (asynchronous). The transaction is abandoned and not retried.

## Timing
- Op visible in cycle 0 (IDLE, stall=1). memReq rises at cycle 1.
- memAck in cycle k≥1 → DONE in cycle k+1 (stall=0, readData valid). EX/MEM advances at the end of cycle k+1.
- Minimum occupancy is 3 cycles per memory op, 2 of them stalled.
- Back-to-back memory ops: IDLE recognises the next op in cycle k+2 and stalls again. No cycle is lost beyond the DONE/IDLE pair.
- Non-memory instructions in IDLE: stall=0 and 1 cycle per instruction.

## Configuration
- Macro MEM_STAGE_TIMEOUT_EN.
- Defined: a CNT_W-bit counter clears on entry to REQ and increments each REQ cycle without memAck. When the counter reaches TIMEOUT:
  - Abort to DONE.
  - Pulse memErr for exactly the DONE cycle.
  - Write 0 into readData if the op was a read.
  - memAck in the same cycle as the limit wins: normal completion, no memErr.
- Undefined: no counter; REQ waits indefinitely; memErr tied 0; TIMEOUT and CNT_W are unused.

## Test plan
- Load, memAck at 1st REQ cycle, address=0x40, memRData=0x1234_5678 → memReq high for exactly 1 cycle, memWe=0, stall high 2 cycles, readData=0x1234_5678 in DONE.
- Store, memAck after 4 REQ cycles, address=0x80, data=0xCAFE_F00D → memWe=1; memAddr/memWData held constant for 4 cycles; stall high 5 cycles; readData unchanged.
- Two loads back-to-back with immediate acks → two distinct requests separated by DONE+IDLE; no re-issue of the first address.
- Non-memory instruction stream with memAck forced high → stall=0, memReq=0 throughout.
- Reset asserted in REQ → memReq, stall-FSM and outputs return to reset values without waiting for clk; a later memAck is ignored.
- MEM_STAGE_TIMEOUT_EN, TIMEOUT=3, no memAck → abort after 3 REQ cycles; memErr=1 for one cycle; readData=0. Repeat with memAck on the 3rd cycle → memErr stays 0.
